// File: rtl/setpoint_entry_ctrl_pkg.sv
// Shared types and helpers for the thermostat setpoint entry controller.
// Key codes and state encoding are used by the keypad and display blocks too.
package setpoint_entry_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EDIT   = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  localparam logic [3:0] KEY_CLR = 4'hA;
  localparam logic [3:0] KEY_ENT = 4'hB;
  localparam logic [3:0] KEY_CAN = 4'hC;

  // d1*10 + d0 as d1*8 + d1*2 + d0
  function automatic logic [6:0] bcd2bin(
    input logic [3:0] d1,
    input logic [3:0] d0
  );
    return {d1, 3'b000}
         + {2'b00, d1, 1'b0}
         + {3'b000, d0};
  endfunction

  function automatic logic [7:0] clamp(
    input logic [7:0] v,
    input logic [7:0] lo,
    input logic [7:0] hi
  );
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Edit-button synchronizer and debouncer.
// Emits a one-cycle press pulse on each accepted 1->0 transition.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic press
);

  localparam int CW =
    (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic          db;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1    <= 1'b1;
      s2    <= 1'b1;
      db    <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      s1    <= btn_n;
      s2    <= s1;
      press <= 1'b0;
      // any return to the accepted level restarts the stability window
      if (s2 == db) begin
        cnt <= '0;
      end else if (cnt == CMAX) begin
        cnt   <= '0;
        db    <= s2;
        press <= ~s2;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/setpoint_entry_ctrl.sv
// Thermostat setpoint entry: button debounce, two-digit keypad entry,
// BCD to binary conversion, clamping and setpoint commit.
module setpoint_entry_ctrl
  import setpoint_entry_ctrl_pkg::*;
#(
  parameter int         DEBOUNCE_CYCLES = 1_000_000,
  parameter int         TIMEOUT_CYCLES  = 250_000_000,
  parameter logic [7:0] SP_MIN          = 8'd10,
  parameter logic [7:0] SP_MAX          = 8'd90,
  parameter logic [7:0] SP_DEFAULT      = 8'd25
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       edit_btn,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic [7:0] setpoint,
  output logic       sp_update,
  output logic       editing,
  output logic [1:0] digit_cnt,
  output logic [3:0] disp_d1,
  output logic [3:0] disp_d0
);

  localparam int TW =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYCLES - 1);

  state_t        state;
  logic          press;
  logic [TW-1:0] tmo;
  logic          k_dig;
  logic          k_clr;
  logic          k_ent;
  logic          k_can;
  logic          k_tmo;
  logic [7:0]    value;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db (
    .clk  (clk),
    .rst_n(rst_n),
    .btn_n(edit_btn),
    .press(press)
  );

  // mutually exclusive event flags; D-F fall through as no key
  assign k_dig = key_valid && (key_code <= 4'd9);
  assign k_clr = key_valid && (key_code == KEY_CLR);
  assign k_ent = key_valid && (key_code == KEY_ENT);
  assign k_can = key_valid && (key_code == KEY_CAN);
  assign k_tmo = !(k_dig || k_clr || k_ent || k_can)
              && (tmo == '0);

  assign value   = {1'b0, bcd2bin(disp_d1, disp_d0)};
  assign editing = (state == ST_EDIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      setpoint  <= SP_DEFAULT;
      sp_update <= 1'b0;
      digit_cnt <= 2'd0;
      disp_d1   <= 4'd0;
      disp_d0   <= 4'd0;
      tmo       <= TMO_LOAD;
    end else begin
      sp_update <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (press) begin
            state     <= ST_EDIT;
            digit_cnt <= 2'd0;
            disp_d1   <= 4'd0;
            disp_d0   <= 4'd0;
            tmo       <= TMO_LOAD;
          end
        end
        ST_EDIT: begin
          if (press) begin
            state <= ST_COMMIT;
          end else begin
            unique case (1'b1)
              k_dig: begin
                disp_d1   <= disp_d0;
                disp_d0   <= key_code;
                digit_cnt <= (digit_cnt == 2'd2)
                           ? 2'd2 : digit_cnt + 2'd1;
                tmo       <= TMO_LOAD;
              end
              k_clr: begin
                disp_d1   <= 4'd0;
                disp_d0   <= 4'd0;
                digit_cnt <= 2'd0;
                tmo       <= TMO_LOAD;
              end
              k_ent: state <= ST_COMMIT;
              k_can: state <= ST_IDLE;
              k_tmo: state <= ST_IDLE;
              default: tmo <= tmo - TW'(1);
            endcase
          end
        end
        ST_COMMIT: begin
          state <= ST_IDLE;
          if (digit_cnt != 2'd0) begin
            setpoint  <= clamp(value, SP_MIN, SP_MAX);
            sp_update <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
